// File: rtl/jump_ctrl_pkg.sv
// Shared types and screen constants for the jump controller and its button conditioning.
// State encoding is fixed so the renderer and debug tooling can decode it directly.
package jump_ctrl_pkg;

    localparam int unsigned GroundLine = 400;
    localparam int unsigned SpriteH    = 43;
    localparam int unsigned CoordW     = 10;
    localparam int unsigned RestY      = GroundLine - SpriteH;

    typedef enum logic [1:0] {
        StGround = 2'd0,
        StRise   = 2'd1,
        StFall   = 2'd2,
        StHover  = 2'd3
    } jump_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jump_ctrl_if.sv
// Control/position bundle between the game sequencer (master) and the jump controller (slave).
interface jump_ctrl_if
    import jump_ctrl_pkg::*;
#(
    parameter int unsigned Y_W = CoordW
) ();

    logic           step;
    logic           stop;
    logic           jump_btn;
    logic [Y_W-1:0] point_y;
    logic           airborne;
    logic           jump_start;

    modport master (
        output step,
        output stop,
        output jump_btn,
        input  point_y,
        input  airborne,
        input  jump_start
    );

    modport slave (
        input  step,
        input  stop,
        input  jump_btn,
        output point_y,
        output airborne,
        output jump_start
    );

endinterface

// File: rtl/jump_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter, debounced level and a
// one-cycle pulse on the cycle the debounced level first reads 1. Also suits the stop switch.
module btn_debounce
    import jump_ctrl_pkg::*;
#(
    parameter int unsigned CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = cnt_width(CYCLES);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/jump_ctrl.sv
// Character jump controller: debounced jump request plus a step-driven rise/fall trajectory.
// Define JUMP_CTRL_HOVER_EN to add a HOVER state that holds the apex while the button is held.
module jump_ctrl
    import jump_ctrl_pkg::*;
#(
    parameter int unsigned GROUND_Y        = RestY,
    parameter int unsigned TOP_Y           = 40,
    parameter int unsigned JUMP_V0         = 12,
    parameter int unsigned GRAVITY         = 1,
    parameter int unsigned MAX_FALL_V      = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
`ifdef JUMP_CTRL_HOVER_EN
    parameter int unsigned HOVER_STEPS     = 6,
`endif
    parameter int unsigned Y_W             = CoordW
) (
    input logic        clk,
    input logic        rst,
    jump_ctrl_if.slave bus
);

    localparam int unsigned AW = Y_W + 1;

    jump_state_e    state_q, state_d, apex_state;
    logic [Y_W-1:0] point_y_q, point_y_d;
    logic [Y_W-1:0] vel_q, vel_d;
    logic           pending_q, pending_d;
    logic           airborne_q;
    logic           launch;
    logic           adv;
    logic           btn_level, btn_rise;

    logic [AW-1:0]  y_ext, rise_y, fall_v_sum, fall_y;
    logic [Y_W-1:0] fall_v;
    logic           below_top, landed;

`ifdef JUMP_CTRL_HOVER_EN
    localparam int unsigned HcW = cnt_width(HOVER_STEPS);
    logic [HcW-1:0] hover_q, hover_d;
`endif

    btn_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.jump_btn),
        .level (btn_level),
        .rise  (btn_rise)
    );

    assign adv = bus.step & ~bus.stop;

    // One extra bit so a rise past row 0 or a fall past the bottom shows up before clamping.
    assign y_ext      = {1'b0, point_y_q};
    assign rise_y     = y_ext - {1'b0, vel_q};
    assign below_top  = rise_y[Y_W] || (rise_y < AW'(TOP_Y));
    assign fall_v_sum = {1'b0, vel_q} + AW'(GRAVITY);
    assign fall_v     = (fall_v_sum > AW'(MAX_FALL_V)) ? Y_W'(MAX_FALL_V) : fall_v_sum[Y_W-1:0];
    assign fall_y     = y_ext + {1'b0, fall_v};
    assign landed     = (fall_y >= AW'(GROUND_Y));

`ifdef JUMP_CTRL_HOVER_EN
    assign apex_state = btn_level ? StHover : StFall;
`else
    logic unused_btn_level;
    assign unused_btn_level = btn_level;
    assign apex_state       = StFall;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StGround;
            point_y_q  <= Y_W'(GROUND_Y);
            vel_q      <= '0;
            pending_q  <= 1'b0;
            airborne_q <= 1'b0;
`ifdef JUMP_CTRL_HOVER_EN
            hover_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            point_y_q  <= point_y_d;
            vel_q      <= vel_d;
            pending_q  <= pending_d;
            airborne_q <= (state_d != StGround);
`ifdef JUMP_CTRL_HOVER_EN
            hover_q    <= hover_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        point_y_d = point_y_q;
        vel_d     = vel_q;
        launch    = 1'b0;
`ifdef JUMP_CTRL_HOVER_EN
        hover_d   = '0;
`endif
        if (adv) begin
            unique case (state_q)
                StGround: begin
                    if (pending_q) begin
                        launch  = 1'b1;
                        vel_d   = Y_W'(JUMP_V0);
                        state_d = StRise;
                    end
                end
                StRise: begin
                    if (below_top) begin
                        point_y_d = Y_W'(TOP_Y);
                        vel_d     = '0;
                        state_d   = apex_state;
                    end else begin
                        point_y_d = rise_y[Y_W-1:0];
                        if (vel_q <= Y_W'(GRAVITY)) begin
                            vel_d   = '0;
                            state_d = apex_state;
                        end else begin
                            vel_d = vel_q - Y_W'(GRAVITY);
                        end
                    end
                end
                StFall: begin
                    if (landed) begin
                        point_y_d = Y_W'(GROUND_Y);
                        vel_d     = '0;
                        state_d   = StGround;
                    end else begin
                        point_y_d = fall_y[Y_W-1:0];
                        vel_d     = fall_v;
                    end
                end
`ifdef JUMP_CTRL_HOVER_EN
                StHover: begin
                    if (!btn_level || hover_q == HcW'(HOVER_STEPS - 1)) begin
                        vel_d   = '0;
                        state_d = StFall;
                    end else begin
                        hover_d = hover_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = StGround;
                end
            endcase
        end
    end

    // A fresh press wins over the launch clear so a re-press on the launch cycle is kept.
    always_comb begin
        pending_d = pending_q;
        if (bus.stop) begin
            pending_d = 1'b0;
        end else begin
            if (launch) begin
                pending_d = 1'b0;
            end
            if (btn_rise) begin
                pending_d = 1'b1;
            end
        end
    end

    always_comb begin
        bus.point_y    = point_y_q;
        bus.airborne   = airborne_q;
        bus.jump_start = launch;
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Randomised bench for jump_ctrl: two instances (default physics and a ceiling-clamp variant)
// checked step by step against precomputed trajectories and a press/pending model.
module tb_jump_ctrl;
    import jump_ctrl_pkg::*;

    localparam int unsigned DEB = 16;
    localparam int GY = 357;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic step = 1'b0;
    logic stop = 1'b0;
    logic btn  = 1'b0;

    int checks = 0;
    int errors = 0;

    jump_ctrl_if bus_a ();
    jump_ctrl_if bus_b ();

    assign bus_a.step     = step;
    assign bus_a.stop     = stop;
    assign bus_a.jump_btn = btn;
    assign bus_b.step     = step;
    assign bus_b.stop     = stop;
    assign bus_b.jump_btn = btn;

    jump_ctrl #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    jump_ctrl #(
        .JUMP_V0         (40),
        .TOP_Y           (300),
        .DEBOUNCE_CYCLES (DEB)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // Model: remaining trajectory per instance, current y and pending press.
    int   traj_a[$];
    int   traj_b[$];
    int   my[2];
    bit   mpend[2];
    logic [9:0] obs_y[2];
    logic obs_air[2], obs_js[2];
    bit   exp_air[2], exp_js[2];

    function automatic void push_y(input int idx, input int y);
        if (idx == 0) traj_a.push_back(y);
        else traj_b.push_back(y);
    endfunction

    // Whole flight as a list of per-step y values, from the launch parameters.
    function automatic void build(input int idx);
        int y, v, yn, top;
        top = (idx == 0) ? 40 : 300;
        v   = (idx == 0) ? 12 : 40;
        y   = GY;
        for (int k = 0; k < 100; k++) begin
            yn = y - v;
            if (yn < top) begin
                push_y(idx, top);
                y = top;
                v = 0;
                break;
            end
            y = yn;
            push_y(idx, y);
            if (v <= 1) begin
                v = 0;
                break;
            end
            v = v - 1;
        end
        for (int k = 0; k < 100; k++) begin
            v  = (v + 1 > 16) ? 16 : v + 1;
            yn = y + v;
            if (yn >= GY) begin
                push_y(idx, GY);
                break;
            end
            y = yn;
            push_y(idx, y);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_step();
        step = 1'b1;
        #1;
        obs_js[0] = bus_a.jump_start;
        obs_js[1] = bus_b.jump_start;
        for (int i = 0; i < 2; i++) begin
            exp_js[i] = 1'b0;
            if (!stop) begin
                if (i == 0 && traj_a.size() != 0) my[0] = traj_a.pop_front();
                else if (i == 1 && traj_b.size() != 0) my[1] = traj_b.pop_front();
                else if (mpend[i]) begin
                    exp_js[i] = 1'b1;
                    mpend[i]  = 1'b0;
                    build(i);
                end
            end
        end
        exp_air[0] = (traj_a.size() != 0);
        exp_air[1] = (traj_b.size() != 0);
        @(posedge clk);
        #1;
        step = 1'b0;
        obs_y[0]   = bus_a.point_y;
        obs_y[1]   = bus_b.point_y;
        obs_air[0] = bus_a.airborne;
        obs_air[1] = bus_b.airborne;
        tick($urandom_range(0, 3));
    endtask

    task automatic press(input int bounces);
        for (int b = 0; b < bounces; b++) begin
            btn = 1'b1;
            tick($urandom_range(1, DEB - 4));
            btn = 1'b0;
            tick($urandom_range(1, 6));
        end
        btn = 1'b1;
        tick(DEB + 8);
        if (!stop) begin
            mpend[0] = 1'b1;
            mpend[1] = 1'b1;
        end
    endtask

    task automatic release_btn();
        btn = 1'b0;
        tick(DEB + 8);
    endtask

    task automatic set_stop(input bit v);
        stop = v;
        if (v) begin
            mpend[0] = 1'b0;
            mpend[1] = 1'b0;
        end
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if (bus_a.point_y !== 10'(GY) || bus_a.airborne !== 1'b0 || bus_a.jump_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: y=%0d air=%b js=%b, expected y=357 air=0 js=0",
                     bus_a.point_y, bus_a.airborne, bus_a.jump_start);
        end
        rst = 1'b0;
        tick(2);
        for (int k = 0; k < 100; k++) begin
            do_step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_y[i] !== 10'(my[i]) || obs_air[i] !== exp_air[i] || obs_js[i] !== exp_js[i]) begin
                    errors++;
                    $display("FAIL idle dut%0d step%0d: y=%0d air=%b js=%b, expected y=%0d air=%b js=%b",
                             i, k, obs_y[i], obs_air[i], obs_js[i], my[i], exp_air[i], exp_js[i]);
                end
            end
        end
    endtask

    task automatic test_bounce_jump();
        int njs;
        njs = 0;
        press(10);
        for (int k = 0; k < 30; k++) begin
            do_step();
            njs += int'(obs_js[0]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_y[i] !== 10'(my[i]) || obs_air[i] !== exp_air[i] || obs_js[i] !== exp_js[i]) begin
                    errors++;
                    $display("FAIL bounce_jump dut%0d step%0d: y=%0d air=%b js=%b, expected y=%0d air=%b js=%b",
                             i, k, obs_y[i], obs_air[i], obs_js[i], my[i], exp_air[i], exp_js[i]);
                end
            end
        end
        checks++;
        if (njs != 1) begin
            errors++;
            $display("FAIL bounce_jump_count: jump_start pulses=%0d, expected 1", njs);
        end
        release_btn();
    endtask

    task automatic test_fall_press();
        int njs, prev;
        bit hit;
        njs = 0;
        hit = 1'b0;
        press($urandom_range(0, 3));
        do_step();
        njs += int'(obs_js[0]);
        release_btn();
        prev = my[0];
        for (int k = 0; k < 40 && !hit; k++) begin
            do_step();
            njs += int'(obs_js[0]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_y[i] !== 10'(my[i]) || obs_air[i] !== exp_air[i] || obs_js[i] !== exp_js[i]) begin
                    errors++;
                    $display("FAIL fall_press dut%0d step%0d: y=%0d air=%b js=%b, expected y=%0d air=%b js=%b",
                             i, k, obs_y[i], obs_air[i], obs_js[i], my[i], exp_air[i], exp_js[i]);
                end
            end
            if (my[0] == 300 && prev < 300) hit = 1'b1;
            prev = my[0];
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL fall_press_reach: y=300 during fall not reached within 40 steps");
        end
        press($urandom_range(0, 3));
        for (int k = 0; k < 40; k++) begin
            do_step();
            njs += int'(obs_js[0]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_y[i] !== 10'(my[i]) || obs_air[i] !== exp_air[i] || obs_js[i] !== exp_js[i]) begin
                    errors++;
                    $display("FAIL fall_press_relaunch dut%0d step%0d: y=%0d air=%b js=%b, expected y=%0d air=%b js=%b",
                             i, k, obs_y[i], obs_air[i], obs_js[i], my[i], exp_air[i], exp_js[i]);
                end
            end
        end
        checks++;
        if (njs != 2) begin
            errors++;
            $display("FAIL fall_press_count: jump_start pulses=%0d, expected 2", njs);
        end
        release_btn();
    endtask

    task automatic test_stop();
        int njs;
        njs = 0;
        press(2);
        do_step();
        release_btn();
        for (int k = 0; k < 5; k++) do_step();
        set_stop(1'b1);
        for (int k = 0; k < 20; k++) begin
            if (k == 8) press(2);
            do_step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_y[i] !== 10'(my[i]) || obs_air[i] !== exp_air[i] || obs_js[i] !== exp_js[i]) begin
                    errors++;
                    $display("FAIL stop_freeze dut%0d step%0d: y=%0d air=%b js=%b, expected y=%0d air=%b js=%b",
                             i, k, obs_y[i], obs_air[i], obs_js[i], my[i], exp_air[i], exp_js[i]);
                end
            end
        end
        set_stop(1'b0);
        for (int k = 0; k < 40; k++) begin
            do_step();
            njs += int'(obs_js[0]) + int'(obs_js[1]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_y[i] !== 10'(my[i]) || obs_air[i] !== exp_air[i] || obs_js[i] !== exp_js[i]) begin
                    errors++;
                    $display("FAIL stop_resume dut%0d step%0d: y=%0d air=%b js=%b, expected y=%0d air=%b js=%b",
                             i, k, obs_y[i], obs_air[i], obs_js[i], my[i], exp_air[i], exp_js[i]);
                end
            end
        end
        checks++;
        if (njs != 0) begin
            errors++;
            $display("FAIL stop_dropped_press: jump_start pulses after stop=%0d, expected 0", njs);
        end
        release_btn();
    endtask

    task automatic test_clamp();
        int miny;
        miny = 1023;
        press($urandom_range(0, 4));
        for (int k = 0; k < 30; k++) begin
            do_step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_y[i] !== 10'(my[i]) || obs_air[i] !== exp_air[i] || obs_js[i] !== exp_js[i]) begin
                    errors++;
                    $display("FAIL clamp dut%0d step%0d: y=%0d air=%b js=%b, expected y=%0d air=%b js=%b",
                             i, k, obs_y[i], obs_air[i], obs_js[i], my[i], exp_air[i], exp_js[i]);
                end
            end
            checks++;
            if (obs_y[1] < 10'd300 || obs_y[1] > 10'd357) begin
                errors++;
                $display("FAIL clamp_range step%0d: y=%0d, expected within 300..357", k, obs_y[1]);
            end
            if (int'(obs_y[1]) < miny) miny = int'(obs_y[1]);
        end
        checks++;
        if (miny != 300) begin
            errors++;
            $display("FAIL clamp_apex: min y=%0d, expected 300", miny);
        end
        release_btn();
    endtask

    task automatic test_rst_mid();
        int njs;
        njs = 0;
        press(1);
        do_step();
        release_btn();
        press(1);
        repeat ($urandom_range(2, 8)) do_step();
        btn = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_a.point_y !== 10'(GY) || bus_a.airborne !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_a: y=%0d air=%b, expected y=357 air=0", bus_a.point_y, bus_a.airborne);
        end
        checks++;
        if (bus_b.point_y !== 10'(GY) || bus_b.airborne !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_b: y=%0d air=%b, expected y=357 air=0", bus_b.point_y, bus_b.airborne);
        end
        my[0] = GY;
        my[1] = GY;
        mpend[0] = 1'b0;
        mpend[1] = 1'b0;
        traj_a.delete();
        traj_b.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);
        for (int k = 0; k < 30; k++) begin
            do_step();
            njs += int'(obs_js[0]) + int'(obs_js[1]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_y[i] !== 10'(my[i]) || obs_air[i] !== exp_air[i] || obs_js[i] !== exp_js[i]) begin
                    errors++;
                    $display("FAIL rst_after dut%0d step%0d: y=%0d air=%b js=%b, expected y=%0d air=%b js=%b",
                             i, k, obs_y[i], obs_air[i], obs_js[i], my[i], exp_air[i], exp_js[i]);
                end
            end
        end
        checks++;
        if (njs != 0) begin
            errors++;
            $display("FAIL rst_pending_cleared: jump_start pulses=%0d, expected 0", njs);
        end
    endtask

    initial begin
        my[0] = GY;
        my[1] = GY;
        mpend[0] = 1'b0;
        mpend[1] = 1'b0;
        test_reset();
        test_bounce_jump();
        test_fall_press();
        test_stop();
        test_clamp();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
